// File: rtl/exe_mem_pkg.sv
// Shared types and defaults for the EXE->MEM elastic pipeline stage.
// Holds the state encoding, the default field widths and the entry layout.
package exe_mem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        FULL  = ST_FULL
    } state_e;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                       ctrl;
        logic [DATA_W_DEF-1:0]       alu_res;
        logic [DATA_W_DEF-1:0]       val_rm;
        logic [REG_ADDR_W_DEF-1:0]   dest;
    } entry_t;

endpackage

// File: rtl/exe_mem_reg.sv
// Enabled register with synchronous active-high clear, one per entry field.
module exe_mem_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM elastic stage: MAIN entry drives the outputs, SKID absorbs one extra entry
// so in_ready depends only on state. Optional forwarding taps under EXE_MEM_FWD_EN.
//
//   state | meaning
//   EMPTY | no valid entry, outputs are a bubble
//   ONE   | MAIN valid, SKID free
//   FULL  | MAIN and SKID valid, input stalled
module exe_mem_stage
    import exe_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  WB_EN,
    input  logic                  MEM_R_EN,
    input  logic                  MEM_W_EN,
    input  logic [DATA_W-1:0]     ALURes,
    input  logic [DATA_W-1:0]     valRm,
    input  logic [REG_ADDR_W-1:0] dest,
`ifdef EXE_MEM_FWD_EN
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATA_W-1:0]     fwd_val,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  WB_EN_OUT,
    output logic                  MEM_R_EN_OUT,
    output logic                  MEM_W_EN_OUT,
    output logic [DATA_W-1:0]     ALUResOut,
    output logic [DATA_W-1:0]     valRmOut,
    output logic [REG_ADDR_W-1:0] destOut
);

    state_e state, state_nxt;
    logic   accept, drain;
    logic   main_en, skid_en, main_from_skid;

    ctrl_t                  in_ctrl, main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0]      main_alu, skid_alu, main_alu_d;
    logic [DATA_W-1:0]      main_rm, skid_rm, main_rm_d;
    logic [REG_ADDR_W-1:0]  main_dest, skid_dest, main_dest_d;

    assign in_ctrl   = '{wb_en: WB_EN, mem_r_en: MEM_R_EN, mem_w_en: MEM_W_EN};
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Flush blocks every register write so a killed input never lands in MAIN or SKID.
    assign main_from_skid = (state == FULL);
    assign main_en = !flush & (((state == EMPTY) & accept) |
                               ((state == ONE) & accept & drain) |
                               ((state == FULL) & drain));
    assign skid_en = !flush & (state == ONE) & accept & !drain;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !drain)      state_nxt = FULL;
                    else if (!accept && drain) state_nxt = EMPTY;
                end
                FULL: if (drain) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_alu_d  = main_from_skid ? skid_alu  : ALURes;
    assign main_rm_d   = main_from_skid ? skid_rm   : valRm;
    assign main_dest_d = main_from_skid ? skid_dest : dest;

    exe_mem_reg #(.W($bits(ctrl_t))) u_main_ctrl (.clk(clk), .rst(rst), .en(main_en), .d(main_ctrl_d), .q(main_ctrl));
    exe_mem_reg #(.W(DATA_W))        u_main_alu  (.clk(clk), .rst(rst), .en(main_en), .d(main_alu_d),  .q(main_alu));
    exe_mem_reg #(.W(DATA_W))        u_main_rm   (.clk(clk), .rst(rst), .en(main_en), .d(main_rm_d),   .q(main_rm));
    exe_mem_reg #(.W(REG_ADDR_W))    u_main_dest (.clk(clk), .rst(rst), .en(main_en), .d(main_dest_d), .q(main_dest));

    exe_mem_reg #(.W($bits(ctrl_t))) u_skid_ctrl (.clk(clk), .rst(rst), .en(skid_en), .d(in_ctrl),  .q(skid_ctrl));
    exe_mem_reg #(.W(DATA_W))        u_skid_alu  (.clk(clk), .rst(rst), .en(skid_en), .d(ALURes),   .q(skid_alu));
    exe_mem_reg #(.W(DATA_W))        u_skid_rm   (.clk(clk), .rst(rst), .en(skid_en), .d(valRm),    .q(skid_rm));
    exe_mem_reg #(.W(REG_ADDR_W))    u_skid_dest (.clk(clk), .rst(rst), .en(skid_en), .d(dest),     .q(skid_dest));

    // Bubbles must never write back or touch memory; data fields simply hold.
    assign WB_EN_OUT    = main_ctrl.wb_en    & out_valid;
    assign MEM_R_EN_OUT = main_ctrl.mem_r_en & out_valid;
    assign MEM_W_EN_OUT = main_ctrl.mem_w_en & out_valid;
    assign ALUResOut    = main_alu;
    assign valRmOut     = main_rm;
    assign destOut      = main_dest;

`ifdef EXE_MEM_FWD_EN
    logic fwd_ok;
    assign fwd_ok   = out_valid & main_ctrl.wb_en & !main_ctrl.mem_r_en;
    assign fwd_hit1 = fwd_ok & (main_dest == src1);
    assign fwd_hit2 = fwd_ok & (main_dest == src2);
    assign fwd_val  = main_alu;
`endif

endmodule
